// File: rtl/ro_scan_meter.sv
// Ring-oscillator frequency scanner: enables one RO at a time, settles, counts synchronised
// rising edges over a fixed gate window and streams each result as a framed byte sequence.
module ro_scan_meter #(
  parameter int NUM_CH        = 125,
  parameter int COUNT_W       = 32,
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ro_in,
  output logic [NUM_CH-1:0] ro_en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cur_ch
);
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FRAME_BYTES = 2 + COUNT_W / 8;
  localparam int BI_W        = $clog2(FRAME_BYTES);
  localparam logic [7:0]      SOF       = 8'hA5;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, SEND, NEXT} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   edge_prev;
  logic                   ro_sel;
  logic                   edge_det;
  logic [31:0]            settle_cnt;
  logic [31:0]            gate_cnt;
  logic [COUNT_W-1:0]     edge_cnt;
  logic [COUNT_W-1:0]     edge_cnt_nxt;
  logic [COUNT_W-1:0]     result;
  logic [BI_W-1:0]        byte_idx;

  // Byte idx of a frame: SOF, channel, then the count MSB-first.
  function automatic logic [7:0] frame_byte(input int idx, input logic [7:0] ch,
                                            input logic [COUNT_W-1:0] cnt);
    logic [COUNT_W-1:0] sh;
    logic [7:0]         b;
    sh = cnt >> (8 * (FRAME_BYTES - 1 - idx));
    if (idx == 0)      b = SOF;
    else if (idx == 1) b = ch;
    else               b = sh[7:0];
    return b;
  endfunction

  assign ro_sel   = ro_in[cur_ch[CH_W-1:0]];
  assign edge_det = sync_pipe[SYNC_STAGES-1] & ~edge_prev;
  assign edge_cnt_nxt = (edge_det && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
      edge_prev <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], ro_sel};
      edge_prev <= sync_pipe[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ro_en      <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_ch     <= '0;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      result     <= '0;
      byte_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_ch     <= '0;
            ro_en      <= NUM_CH'(1);
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 32'(SETTLE_CYCLES - 1)) begin
            edge_cnt <= '0;
            gate_cnt <= '0;
            state    <= GATE;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        GATE: begin
          edge_cnt <= edge_cnt_nxt;
          if (gate_cnt == 32'(GATE_CYCLES - 1)) begin
            result   <= edge_cnt_nxt;
            ro_en    <= '0;
            byte_idx <= '0;
            state    <= SEND;
          end else begin
            gate_cnt <= gate_cnt + 32'd1;
          end
        end
        SEND: begin
          // First SEND cycle only loads byte 0; afterwards advance on each accept.
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= frame_byte(0, cur_ch, result);
          end else if (tx_ready) begin
            if (byte_idx == LAST_BYTE) begin
              tx_valid <= 1'b0;
              state    <= NEXT;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              tx_data  <= frame_byte(int'(byte_idx) + 1, cur_ch, result);
            end
          end
        end
        NEXT: begin
          settle_cnt <= '0;
          if (cur_ch != 8'(NUM_CH - 1)) begin
            cur_ch <= cur_ch + 8'd1;
            ro_en  <= NUM_CH'(1) << (cur_ch + 8'd1);
            state  <= SETTLE;
          end else if (continuous) begin
            cur_ch <= '0;
            ro_en  <= NUM_CH'(1);
            state  <= SETTLE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ro_scan_meter.sv
// Directed bench for ro_scan_meter: a 4-channel 32-bit instance and a 1-channel 8-bit
// instance driven by deterministic square waves whose periods divide the gate window.
module tb_ro_scan_meter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic       reset_a = 1'b1, start_a = 1'b0, cont_a = 1'b0, rdy_a = 1'b1;
  logic [3:0] ro_a = '0, en_a;
  logic [7:0] txd_a, ch_a;
  logic       txv_a, busy_a, done_a;

  logic       reset_b = 1'b1, start_b = 1'b0, cont_b = 1'b0, rdy_b = 1'b1;
  logic [0:0] ro_b = '0, en_b;
  logic [7:0] txd_b, ch_b;
  logic       txv_b, busy_b, done_b;

  ro_scan_meter #(.NUM_CH(4), .COUNT_W(32), .GATE_CYCLES(100), .SETTLE_CYCLES(8),
                  .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(reset_a), .start(start_a), .continuous(cont_a), .ro_in(ro_a),
    .ro_en(en_a), .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(rdy_a), .busy(busy_a),
    .done(done_a), .cur_ch(ch_a));

  ro_scan_meter #(.NUM_CH(1), .COUNT_W(8), .GATE_CYCLES(1000), .SETTLE_CYCLES(8),
                  .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset(reset_b), .start(start_b), .continuous(cont_b), .ro_in(ro_b),
    .ro_en(en_b), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(rdy_b), .busy(busy_b),
    .done(done_b), .cur_ch(ch_b));

  // Per-channel periods (clk cycles) and resulting edge counts over a 100-cycle gate.
  int period_a [4] = '{4, 10, 20, 50};
  int cnt_a    [4] = '{25, 10, 5, 2};
  logic [7:0] exp_a [24];
  int   cyc    = 0;
  logic b_mode = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      for (int c = 0; c < 4; c++) ro_a[c] = (cyc % period_a[c]) < (period_a[c] / 2);
      ro_b[0] = b_mode ? cyc[0] : ((cyc % 4) < 2);
    end
  end

  logic [7:0] qa [$];
  logic [7:0] qb [$];
  int   done_a_cnt = 0, done_b_cnt = 0;
  logic onehot_bad = 1'b0, send_en_bad = 1'b0, done_busy_bad = 1'b0;

  always @(negedge clk) begin
    if (txv_a && rdy_a) qa.push_back(txd_a);
    if (txv_b && rdy_b) qb.push_back(txd_b);
    if (done_a) done_a_cnt <= done_a_cnt + 1;
    if (done_b) done_b_cnt <= done_b_cnt + 1;
    if (!$onehot0(en_a)) onehot_bad <= 1'b1;
    if (txv_a && (en_a != 4'b0)) send_en_bad <= 1'b1;
    if (done_a && busy_a) done_busy_bad <= 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (3) tick();
    checks++; if (en_a !== 4'b0) $display("FAIL reset_ro_en: got %b want 0000", en_a); else passed++;
    checks++; if (txv_a !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", txv_a); else passed++;
    checks++; if (txd_a !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", txd_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
    checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
    checks++; if (ch_a !== 8'h00) $display("FAIL reset_cur_ch: got %h want 00", ch_a); else passed++;
    checks++; if (en_b !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_b: en %b busy %b want 0 0", en_b, busy_b); else passed++;
    reset_a = 1'b0; reset_b = 1'b0;
    tick();
  endtask

  task automatic test_scan();
    int n, base, d0;
    base = qa.size(); d0 = done_a_cnt;
    start_a = 1'b1; tick(); start_a = 1'b0;
    checks++; if (busy_a !== 1'b1 || en_a !== 4'b0001) $display("FAIL scan_start: busy %b en %b want 1 0001", busy_a, en_a); else passed++;
    n = 0; while (done_a_cnt == d0 && n < 2000) begin tick(); n++; end
    checks++; if (done_a_cnt == d0) $display("FAIL scan_timeout: no done after %0d cycles", n); else passed++;
    repeat (3) tick();
    checks++; if (done_a_cnt - d0 != 1) $display("FAIL scan_done_count: got %0d want 1", done_a_cnt - d0); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL scan_busy_end: got %b want 0", busy_a); else passed++;
    checks++; if (qa.size() - base != 24) $display("FAIL scan_len: got %0d want 24", qa.size() - base); else passed++;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (base + i >= qa.size() || qa[base + i] !== exp_a[i])
        $display("FAIL scan_byte%0d: got %h want %h", i, (base + i < qa.size()) ? qa[base + i] : 8'hxx, exp_a[i]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    int n, base, d0;
    logic [7:0] hold;
    logic stall_bad;
    base = qa.size(); d0 = done_a_cnt; stall_bad = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; while (qa.size() - base < 3 && n < 500) begin tick(); n++; end
    checks++; if (qa.size() - base < 3) $display("FAIL stall_timeout: %0d bytes seen want 3", qa.size() - base); else passed++;
    rdy_a = 1'b0;
    hold = txd_a;
    checks++; if (txv_a !== 1'b1 || hold !== 8'h00) $display("FAIL stall_first: valid %b data %h want 1 00", txv_a, hold); else passed++;
    repeat (20) begin
      tick();
      if (txv_a !== 1'b1 || txd_a !== hold) stall_bad = 1'b1;
    end
    checks++; if (stall_bad) $display("FAIL stall_hold: valid %b data %h want 1 %h", txv_a, txd_a, hold); else passed++;
    checks++; if (qa.size() - base != 3) $display("FAIL stall_no_accept: got %0d bytes want 3", qa.size() - base); else passed++;
    rdy_a = 1'b1;
    n = 0; while (done_a_cnt == d0 && n < 2000) begin tick(); n++; end
    tick();
    checks++; if (done_a_cnt - d0 != 1) $display("FAIL stall_done: got %0d want 1", done_a_cnt - d0); else passed++;
    checks++; if (qa.size() - base != 24) $display("FAIL stall_len: got %0d want 24", qa.size() - base); else passed++;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (base + i >= qa.size() || qa[base + i] !== exp_a[i])
        $display("FAIL stall_byte%0d: got %h want %h", i, (base + i < qa.size()) ? qa[base + i] : 8'hxx, exp_a[i]);
      else passed++;
    end
    checks++; if (send_en_bad) $display("FAIL stall_ro_en_in_send: got nonzero want 0000"); else passed++;
  endtask

  task automatic test_saturate();
    int n, base, d0;
    logic [7:0] eb [3];
    for (int m = 0; m < 2; m++) begin
      b_mode = (m == 1);
      eb = '{8'hA5, 8'h00, (m == 1) ? 8'hFF : 8'hFA};
      base = qb.size(); d0 = done_b_cnt;
      start_b = 1'b1; tick(); start_b = 1'b0;
      n = 0; while (done_b_cnt == d0 && n < 3000) begin tick(); n++; end
      tick();
      checks++; if (done_b_cnt - d0 != 1) $display("FAIL sat%0d_done: got %0d want 1", m, done_b_cnt - d0); else passed++;
      checks++; if (qb.size() - base != 3) $display("FAIL sat%0d_len: got %0d want 3", m, qb.size() - base); else passed++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (base + i >= qb.size() || qb[base + i] !== eb[i])
          $display("FAIL sat%0d_byte%0d: got %h want %h", m, i, (base + i < qb.size()) ? qb[base + i] : 8'hxx, eb[i]);
        else passed++;
      end
    end
    checks++; if (ch_b !== 8'h00) $display("FAIL sat_cur_ch: got %h want 00", ch_b); else passed++;
  endtask

  task automatic test_continuous();
    int n, base, d0;
    base = qa.size(); d0 = done_a_cnt;
    cont_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; while (qa.size() - base < 24 && n < 2000) begin tick(); n++; end
    checks++; if (qa.size() - base < 24) $display("FAIL cont_timeout: %0d bytes want 24", qa.size() - base); else passed++;
    repeat (3) tick();
    checks++; if (en_a !== 4'b0001) $display("FAIL cont_wrap_en: got %b want 0001", en_a); else passed++;
    checks++; if (busy_a !== 1'b1 || ch_a !== 8'h00) $display("FAIL cont_wrap_state: busy %b ch %h want 1 00", busy_a, ch_a); else passed++;
    checks++; if (done_a_cnt != d0) $display("FAIL cont_no_done: got %0d want 0", done_a_cnt - d0); else passed++;
    n = 0; while (ch_a != 8'd2 && n < 1000) begin tick(); n++; end
    cont_a = 1'b0;
    n = 0; while (done_a_cnt == d0 && n < 2000) begin tick(); n++; end
    tick();
    checks++; if (done_a_cnt - d0 != 1) $display("FAIL cont_done: got %0d want 1", done_a_cnt - d0); else passed++;
    checks++; if (done_busy_bad || busy_a !== 1'b0) $display("FAIL cont_busy_fall: busy %b overlap %b want 0 0", busy_a, done_busy_bad); else passed++;
    checks++; if (qa.size() - base != 48) $display("FAIL cont_len: got %0d want 48", qa.size() - base); else passed++;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (base + 24 + i >= qa.size() || qa[base + 24 + i] !== exp_a[i])
        $display("FAIL cont_byte%0d: got %h want %h", i, (base + 24 + i < qa.size()) ? qa[base + 24 + i] : 8'hxx, exp_a[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int n, base, d0;
    d0 = done_a_cnt;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; while (ch_a != 8'd2 && n < 1000) begin tick(); n++; end
    repeat (20) tick();
    checks++; if (en_a !== 4'b0100) $display("FAIL rstmid_in_gate: en %b want 0100", en_a); else passed++;
    reset_a = 1'b1; tick();
    checks++; if (en_a !== 4'b0 || txv_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL rstmid_abort: en %b valid %b busy %b want 0000 0 0", en_a, txv_a, busy_a); else passed++;
    reset_a = 1'b0; tick();
    checks++; if (done_a_cnt != d0) $display("FAIL rstmid_no_done: got %0d want 0", done_a_cnt - d0); else passed++;
    base = qa.size();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; while (done_a_cnt == d0 && n < 2000) begin tick(); n++; end
    tick();
    checks++; if (qa.size() - base != 24) $display("FAIL rstmid_len: got %0d want 24", qa.size() - base); else passed++;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (base + i >= qa.size() || qa[base + i] !== exp_a[i])
        $display("FAIL rstmid_byte%0d: got %h want %h", i, (base + i < qa.size()) ? qa[base + i] : 8'hxx, exp_a[i]);
      else passed++;
    end
  endtask

  task automatic test_start_busy();
    int n, base, d0;
    base = qa.size(); d0 = done_a_cnt;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; while (txv_a !== 1'b1 && n < 500) begin tick(); n++; end
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; while (!(ch_a == 8'd2 && txv_a === 1'b1) && n < 1000) begin tick(); n++; end
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; while (done_a_cnt == d0 && n < 2000) begin tick(); n++; end
    repeat (3) tick();
    checks++; if (done_a_cnt - d0 != 1) $display("FAIL busystart_done: got %0d want 1", done_a_cnt - d0); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL busystart_idle: busy %b want 0", busy_a); else passed++;
    checks++; if (qa.size() - base != 24) $display("FAIL busystart_len: got %0d want 24", qa.size() - base); else passed++;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (base + i >= qa.size() || qa[base + i] !== exp_a[i])
        $display("FAIL busystart_byte%0d: got %h want %h", i, (base + i < qa.size()) ? qa[base + i] : 8'hxx, exp_a[i]);
      else passed++;
    end
    checks++; if (onehot_bad) $display("FAIL onehot_ro_en: multiple bits seen want at most one"); else passed++;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      exp_a[c*6+0] = 8'hA5;
      exp_a[c*6+1] = 8'(c);
      exp_a[c*6+2] = 8'h00;
      exp_a[c*6+3] = 8'h00;
      exp_a[c*6+4] = 8'h00;
      exp_a[c*6+5] = 8'(cnt_a[c]);
    end
    test_reset();
    test_scan();
    test_stall();
    test_saturate();
    test_continuous();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
